// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: pin conditioning, frame FSM with timeout, scan-code FIFO, error count.
// Define PS2_DECODE_EN to fold E0/F0 prefix bytes into the {ext, brk} bits of the stored code.
`timescale 1ns/1ps
module ps2_keyboard_rx #(
  parameter int DEPTH_LOG2 = 3,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 50000
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  readn,
  output logic [9:0]            data,
  output logic                  ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  err,
  output logic [7:0]            err_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [TW-1:0]         TO_ONE  = 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]            sync_clk, sync_dat;
  logic [3:0]            flt_cnt;
  logic                  filt, filt_d;
  logic [FILTER_LEN-1:0] dly;
  logic                  fall, bit_in;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_clk <= 2'b11;
      sync_dat <= 2'b11;
      flt_cnt  <= '0;
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      dly      <= '1;
    end else begin
      sync_clk <= {sync_clk[0], ps2_clk};
      sync_dat <= {sync_dat[0], ps2_data};
      filt_d   <= filt;
      dly[0]   <= sync_dat[1];
      for (int i = 1; i < FILTER_LEN; i++) dly[i] <= dly[i-1];
      if (sync_clk[1] == filt)
        flt_cnt <= '0;
      else if (flt_cnt == 4'(FILTER_LEN)) begin
        filt    <= sync_clk[1];
        flt_cnt <= '0;
      end else
        flt_cnt <= flt_cnt + 4'd1;
    end
  end

  // data delay line keeps each bit aligned with the filtered clock edge
  assign fall   = filt_d & ~filt;
  assign bit_in = dly[FILTER_LEN-1];

  state_t        state, state_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [2:0]    idx, idx_nxt;
  logic          par, par_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic          err_nxt, frame_ok, push;
  logic [9:0]    push_data;
`ifdef PS2_DECODE_EN
  logic          ext, brk, ext_nxt, brk_nxt;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      shreg   <= '0;
      idx     <= '0;
      par     <= 1'b0;
      to_cnt  <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
`ifdef PS2_DECODE_EN
      ext     <= 1'b0;
      brk     <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      idx    <= idx_nxt;
      par    <= par_nxt;
      to_cnt <= to_nxt;
      err    <= err_nxt;
      if (err_nxt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`ifdef PS2_DECODE_EN
      ext    <= ext_nxt;
      brk    <= brk_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    idx_nxt   = idx;
    par_nxt   = par;
    to_nxt    = to_cnt;
    err_nxt   = 1'b0;
    frame_ok  = 1'b0;
    if (state == IDLE) begin
      to_nxt = '0;
      if (fall) begin
        if (!bit_in) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end else
          err_nxt = 1'b1;
      end
    end else if (fall) begin
      to_nxt = '0;
      case (state)
        DATA: begin
          shreg_nxt = {bit_in, shreg[7:1]};
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_nxt   = bit_in;
          state_nxt = STOP;
        end
        default: begin
          state_nxt = IDLE;
          if (bit_in && (^{shreg, par})) frame_ok = 1'b1;
          else err_nxt = 1'b1;
        end
      endcase
    end else if (to_cnt == TW'(TIMEOUT)) begin
      state_nxt = IDLE;
      to_nxt    = '0;
      err_nxt   = 1'b1;
    end else
      to_nxt = to_cnt + TO_ONE;
  end

`ifdef PS2_DECODE_EN
  always_comb begin
    ext_nxt   = ext;
    brk_nxt   = brk;
    push      = 1'b0;
    push_data = {ext, brk, shreg};
    if (frame_ok) begin
      if (shreg == 8'hE0) ext_nxt = 1'b1;
      else if (shreg == 8'hF0) brk_nxt = 1'b1;
      else begin
        push    = 1'b1;
        ext_nxt = 1'b0;
        brk_nxt = 1'b0;
      end
    end
  end
`else
  assign push      = frame_ok;
  assign push_data = {2'b00, shreg};
`endif

  logic [9:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic                  pop, full, wr_en;

  assign ready = (count != '0);
  assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign pop   = ~readn & ready;
  // a full FIFO still accepts a push when a pop frees the head slot in the same cycle
  assign wr_en = push & (~full | pop);
  assign data  = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (pop)   rptr <= rptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (pop) overflow <= 1'b0;
      else if (push && full) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: vector table, directed corner sequences, random frames vs a queue model.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;
  localparam int DL = 3, FL = 4, TO = 300, HALF = 12, DEPTH = 8;

  logic clk = 1'b0, clrn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, readn = 1'b1;
  logic [9:0] data;
  logic ready, overflow, err;
  logic [DL:0] count;
  logic [7:0] err_cnt;

  ps2_keyboard_rx #(.DEPTH_LOG2(DL), .FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .readn(readn),
    .data(data), .ready(ready), .count(count), .overflow(overflow), .err(err), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int err_hi = 0, err_pulses = 0;
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    if (err === 1'b1) err_hi++;
    if (err === 1'b1 && err_prev !== 1'b1) err_pulses++;
    err_prev = err;
  end

  // reference model: queue of stored entries plus sticky/accumulated status
  logic [9:0] mq[$];
  bit m_ovf = 0, m_ext = 0, m_brk = 0;
  int m_errs = 0;

  function automatic void m_push(logic [9:0] v);
    if (mq.size() < DEPTH) mq.push_back(v);
    else m_ovf = 1;
  endfunction

  function automatic void m_byte(logic [7:0] c);
`ifdef PS2_DECODE_EN
    if (c == 8'hE0) m_ext = 1;
    else if (c == 8'hF0) m_brk = 1;
    else begin
      m_push({m_ext, m_brk, c});
      m_ext = 0;
      m_brk = 0;
    end
`else
    m_push({2'b00, c});
`endif
  endfunction

  function automatic void m_err();
    if (m_errs < 255) m_errs++;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(bit b);
    ps2_data = b;
    clks(HALF);
    ps2_clk = 1'b0;
    clks(HALF);
    ps2_clk = 1'b1;
  endtask

  // mode: 0 good, 1 bad parity, 2 bad stop, 3 lone fall with data high
  task automatic send_frame(logic [7:0] c, int mode);
    logic p;
    if (mode == 3) begin
      ps2_bit(1'b1);
      m_err();
    end else begin
      p = ~^c;
      if (mode == 1) p = ~p;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(c[i]);
      ps2_bit(p);
      ps2_bit(mode == 2 ? 1'b0 : 1'b1);
      if (mode == 0) m_byte(c);
      else m_err();
    end
    ps2_data = 1'b1;
    clks(HALF);
  endtask

  task automatic send_partial(logic [7:0] c);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(c[i]);
    ps2_data = 1'b1;
  endtask

  task automatic frame_latency(logic [7:0] c);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit(~^c);
    ps2_data = 1'b1;
    clks(HALF);
    ps2_clk = 1'b0;
    clks(7);
    check("lat_ready_edge6", ready, 0);
    clks(1);
    check("lat_ready_edge7", ready, 1);
    check("lat_data_edge7", data, {2'b00, c});
    check("lat_count_edge7", count, 1);
    clks(HALF - 8);
    ps2_clk = 1'b1;
    clks(HALF);
    m_byte(c);
  endtask

  task automatic pop_one();
    if (mq.size() > 0) check("pop_head", data, mq[0]);
    readn = 1'b0;
    clks(1);
    readn = 1'b1;
    if (mq.size() > 0) begin
      void'(mq.pop_front());
      m_ovf = 0;
    end
  endtask

  task automatic check_model(string tag);
    check({tag, "_count"}, count, mq.size());
    check({tag, "_overflow"}, overflow, m_ovf);
    check({tag, "_err_cnt"}, err_cnt, m_errs);
    if (mq.size() > 0) check({tag, "_head"}, data, mq[0]);
  endtask

  task automatic apply_reset();
    clrn = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    readn = 1'b1;
    clks(3);
    check("rst_ready", ready, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);
    clrn = 1'b1;
    mq.delete();
    m_ovf = 0; m_ext = 0; m_brk = 0; m_errs = 0;
    clks(2);
  endtask

  typedef struct {
    logic [7:0] code;
    int         mode;
    int         exp_err;
    int         exp_push;
  } vec_t;
  vec_t vt[8];

  initial begin
    int p0, h0, exp_cnt;
    vt[0] = '{8'h55, 0, 0, 1};
    vt[1] = '{8'hAA, 0, 0, 1};
    vt[2] = '{8'h12, 1, 1, 0};
    vt[3] = '{8'h34, 2, 1, 0};
    vt[4] = '{8'h00, 0, 0, 1};
    vt[5] = '{8'hFF, 0, 0, 1};
    vt[6] = '{8'h00, 3, 1, 0};
    vt[7] = '{8'h80, 0, 0, 1};

    apply_reset();

    frame_latency(8'h1C);
    pop_one();
    check("single_ready_after_pop", ready, 0);

    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      p0 = err_pulses;
      send_frame(vt[i].code, vt[i].mode);
      exp_cnt += vt[i].exp_push;
      check($sformatf("vec%0d_err_pulses", i), err_pulses - p0, vt[i].exp_err);
      check($sformatf("vec%0d_count", i), count, exp_cnt);
      check_model($sformatf("vec%0d", i));
    end
    while (mq.size() > 0) pop_one();
    check("vec_drained", ready, 0);

    apply_reset();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0);
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_head", data, 10'h001);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("ovf_pop%0d", i), data, i);
      pop_one();
      if (i == 1) check("ovf_cleared", overflow, 0);
    end
    check("ovf_empty", ready, 0);

    apply_reset();
    p0 = err_pulses; h0 = err_hi;
    send_frame(8'h5A, 1);
    send_frame(8'h5A, 2);
    check("perr_count", count, 0);
    check("perr_err_cnt", err_cnt, 2);
    check("perr_pulses", err_pulses - p0, 2);
    check("perr_width", err_hi - h0, 2);

    apply_reset();
    p0 = err_pulses; h0 = err_hi;
    send_partial(8'h2A);
    clks(TO + 50);
    m_err();
    check("to_pulses", err_pulses - p0, 1);
    check("to_width", err_hi - h0, 1);
    check("to_err_cnt", err_cnt, 1);
    send_frame(8'h2A, 0);
    check("to_count", count, 1);
    check("to_data", data, 10'h02A);

    p0 = err_pulses;
    ps2_data = 1'b1;
    for (int g = 1; g <= 3; g++) begin
      ps2_clk = 1'b0;
      clks(g);
      ps2_clk = 1'b1;
      clks(12);
    end
    check("glitch_pulses", err_pulses - p0, 0);
    check_model("glitch");

    send_partial(8'h99);
    apply_reset();
    send_frame(8'h3C, 0);
    check("post_rst_count", count, 1);
    check("post_rst_data", data, 10'h03C);
    pop_one();

    apply_reset();
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h74, 0);
`ifdef PS2_DECODE_EN
    check("dec_a_count", count, 1);
    check("dec_a_head", data, 10'h374);
`else
    check("dec_a_count", count, 3);
    check("dec_a_head", data, 10'h0E0);
`endif
    check_model("dec_a");
    while (mq.size() > 0) pop_one();
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
`ifdef PS2_DECODE_EN
    check("dec_b_count", count, 1);
    check("dec_b_head", data, 10'h11C);
`else
    check("dec_b_count", count, 2);
    check("dec_b_head", data, 10'h0F0);
`endif
    check_model("dec_b");
    while (mq.size() > 0) pop_one();

    apply_reset();
    for (int k = 0; k < 60; k++) begin
      int r, npop;
      logic [7:0] c;
      c = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      send_frame(c, r == 0 ? 1 : (r == 1 ? 2 : 0));
      check_model($sformatf("rnd%0d", k));
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop; j++) pop_one();
    end

    apply_reset();
    for (int k = 0; k < 258; k++) send_frame(8'h00, 3);
    check("sat_err_cnt", err_cnt, 255);
    check_model("sat");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
